data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
// Memory-side responder for the CPU data-bus requests (load / bus_write) issued by the control path.
// It accepts one word load or store at a time and inserts WAIT_CYCLES wait states, signalled on stall.
// On completion it returns read data with a one-cycle done pulse; illegal requests are rejected via err.
// It sits between the CPU datapath and a synchronous word-addressed data RAM held inside this block.
// PARAMETERS
// ADDR_W       8   word-address width; RAM depth = 2**ADDR_W words
// DATA_W       32  data word width
// WAIT_CYCLES  2   wait states per access, legal range 0..15
// PORTS
// clk        in   1       rising-edge clock
// rst        in   1       asynchronous reset, active-low
// load       in   1       read request (level; sampled only in IDLE)
// bus_write  in   1       write request (level; sampled only in IDLE)
// addr       in   32      byte address; bits[1:0] must be 0
// wdata      in   DATA_W  store data
// rdata      out  DATA_W  load data, valid while done=1 for a load; holds value until next load completes
// stall      out  1       1 while an accepted request is in wait states
// done       out  1       one-cycle completion pulse
// err        out  1       one-cycle pulse: request rejected
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, cnt=0, stall=0, done=0, err=0, rdata=0; RAM contents not cleared.
// - Reset mid-access: the pending access is discarded; a pending write never reaches RAM.
// - FSM states: IDLE, WAIT, DONE. All outputs are registered.
// - IDLE, rising edge, exactly one of load/bus_write high, addr[1:0]==0: latch op, addr, wdata -> accept.
//   - WAIT_CYCLES>0: go to WAIT, cnt<=WAIT_CYCLES, stall<=1.
//   - WAIT_CYCLES==0: perform the access on the same edge, go to DONE.
// - IDLE, both load and bus_write high, or addr[1:0]!=0: err<=1 for one cycle.
//   No access is made, state stays IDLE, stall stays 0.
// - IDLE, neither request high: hold.
// - WAIT, each edge: if cnt==1, perform the access, go to DONE, stall<=0; else cnt<=cnt-1.
//   - stall is high for exactly WAIT_CYCLES cycles.
// - Access: word index = latched addr[ADDR_W+1:2]; upper address bits are ignored, so addresses alias modulo depth.
//   - write: RAM[idx]<=wdata_latched
//   - read: rdata<=RAM[idx]
// - DONE: done=1 for this single cycle. Next edge -> IDLE unconditionally. Requests are not sampled in DONE.
//   Requests are next sampled on the edge leaving the following IDLE cycle.
// - Latency: accept edge E; done is high in the cycle after edge E+WAIT_CYCLES; rdata is valid in that cycle.
// - Changes on load/bus_write/addr/wdata while in WAIT or DONE are ignored; latched values are used.
// - Minimum issue interval: WAIT_CYCLES+2 cycles between accepted requests.
// - done and err are never high in the same cycle; stall and done are never high in the same cycle.
// TESTING
// 1. WAIT_CYCLES=2: store 0xDEADBEEF @0x10 -> stall=1 for 2 cycles, done pulse 1 cycle, err=0.
//    Then load @0x10 -> same timing, rdata=0xDEADBEEF during done.
// 2. load with addr=0x13 -> err=1 for exactly 1 cycle; stall=0, done=0; RAM[4] unchanged.
// 3. load=1 and bus_write=1 together @0x20 -> err pulse, no access; following load @0x20 returns the prior value.
// 4. store 0x1234 @0x08, then change addr to 0x0C and wdata to 0xFFFF during stall
//    -> RAM[2]=0x1234, RAM[3] unchanged.
// 5. store 0xA5A5A5A5 @0x30, assert rst=0 during WAIT -> stall/done/err/rdata=0 immediately;
//    after release, load @0x30 returns the pre-store value.
// 6. ADDR_W=8: store 0x77 @0x400, then load @0x000 -> rdata=0x77 (aliasing).
//    With WAIT_CYCLES=0: done in the cycle right after accept, stall never high.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// CPU data-bus bundle between the control path (master) and the data-memory responder (slave).
// Carries load/store requests, the store word, and the stall/done/err/rdata responses.
interface data_mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              load;
    logic              bus_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output load, bus_write, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  load, bus_write, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM with a wait-state responder: one load or store at a time,
// WAIT_CYCLES stall cycles, then a one-cycle done pulse; malformed requests get an err pulse.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                stall_reg, stall_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                op_write_reg, op_write_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg;

    logic                access;
    logic                acc_write;
    logic [ADDR_W-1:0]   acc_idx;
    logic [DATA_W-1:0]   acc_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Upper address bits only select an alias of the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2]};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        stall_next    = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        op_write_next = op_write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        access        = 1'b0;
        acc_write     = op_write_reg;
        acc_idx       = addr_reg;
        acc_wdata     = wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if ((bus.load && bus.bus_write) ||
                    ((bus.load || bus.bus_write) && (bus.addr[1:0] != 2'b00))) begin
                    err_next = 1'b1;
                end else if (bus.load || bus.bus_write) begin
                    op_write_next = bus.bus_write;
                    addr_next     = bus.addr[ADDR_W+1:2];
                    wdata_next    = bus.wdata;
                    if (WAIT_CYCLES == 0) begin
                        // Zero-wait: the access happens on the accept edge itself.
                        access     = 1'b1;
                        acc_write  = bus.bus_write;
                        acc_idx    = bus.addr[ADDR_W+1:2];
                        acc_wdata  = bus.wdata;
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                        stall_next = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    access     = 1'b1;
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next   = cnt_reg - 4'd1;
                    stall_next = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            stall_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            stall_reg    <= stall_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            op_write_reg <= op_write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            if (access && !acc_write) begin
                rdata_reg <= mem[acc_idx];
            end
        end
    end

    // RAM contents survive reset; a reset mid-access forces IDLE so no write is issued.
    always_ff @(posedge clk) begin
        if (access && acc_write) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.stall = stall_reg;
    assign bus.done  = done_reg;
    assign bus.err   = err_reg;
endmodule
